stream_combiner: RTL and testbench
==================================

STREAM_COMBINER -- requirements
Module: stream_combiner

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-lane buffer depth in 32-bit words; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  synchronous clear of all buffered data; does not clear counters or error.
REQ-005 data_port1  input  32  lane-1 word (upper half of the output).
REQ-006 valid1  input  1  data_port1 holds a word.
REQ-007 ready1  output  1  lane-1 buffer can accept a word.
REQ-008 data_port2  input  32  lane-2 word (lower half of the output).
REQ-009 valid2  input  1  data_port2 holds a word.
REQ-010 ready2  output  1  lane-2 buffer can accept a word.
REQ-011 master_data  output  64  combined word.
REQ-012 valid_out  output  1  master_data holds a word.
REQ-013 ready_out  input  1  downstream accepts master_data.
REQ-014 pair_count  output  32  number of 64-bit words accepted downstream.
REQ-015 skew_err  output  1  sticky lane-skew error flag.

Function
REQ-016 A lane word SHALL be accepted on an edge where validN and readyN are both 1; each lane SHALL write into its own FIFO_DEPTH-entry FIFO.
REQ-017 readyN SHALL be 1 exactly when lane-N occupancy < FIFO_DEPTH, derived from registered state only, with no combinational path from validN.
REQ-018 Lane FIFOs SHALL preserve order; lane words SHALL be paired strictly by arrival index (k-th lane-1 word with k-th lane-2 word).
REQ-019 Output register SHALL load {lane-1 head, lane-2 head} into master_data[63:32]/[31:0] on an edge where both FIFOs are non-empty and (valid_out == 0 or ready_out == 1); both heads SHALL pop on that edge.
REQ-020 Latency: a pair whose later word is accepted at edge N SHALL appear with valid_out = 1 after edge N+1 when the output register is free.
REQ-021 When both FIFOs hold data and ready_out = 1, one 64-bit word SHALL be produced every cycle with no bubbles.
REQ-022 While valid_out = 1 and ready_out = 0, master_data and valid_out SHALL hold stable.
REQ-023 valid_out SHALL clear on an edge where ready_out = 1 and no new pair is loadable.
REQ-024 Push and pop on the same lane on the same edge SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 pair_count SHALL increment by 1 on each edge with valid_out and ready_out both 1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 skew_err SHALL set on an edge where one lane FIFO is full and the other is empty; it SHALL stay set until reset.
REQ-027 flush = 1 SHALL, on that edge, empty both FIFOs and clear valid_out, and SHALL discard any push or pop presented on that edge.
REQ-028 No word SHALL be lost or duplicated under any valid/ready pattern on any port.

Reset
REQ-029 On an edge with rst_n = 0, these values SHALL apply, overriding flush and all handshakes:
- both FIFOs empty
- ready1 = ready2 = 1 (from the following cycle)
- valid_out = 0
- master_data = 0
- pair_count = 0
- skew_err = 0
REQ-030 Reset asserted mid-stream SHALL discard all buffered and output-held words.

Verification
REQ-031 Balanced stream: lanes present 0x11111111 and 0x22222222 together, ready_out = 1 -> master_data = 0x1111111122222222 one cycle later; pair_count = 1.
REQ-032 Skewed lanes: lane 1 sends A0..A3, then lane 2 sends B0..B3 -> outputs {A0,B0}..{A3,B3} in order; skew_err = 1 (lane 1 full, lane 2 empty); ready1 = 0 while lane 1 is full.
REQ-033 Backpressure: ready_out = 0 for 10 cycles during a continuous stream -> master_data stable, ready1/ready2 drop after 4 buffered words, no loss after release.
REQ-034 Throughput: 1000 pairs with all valids and ready_out held 1 -> 1000 outputs on consecutive cycles after the first; pair_count = 1000.
REQ-035 Flush with 3 words buffered and valid_out = 1 -> next cycle valid_out = 0, ready1 = ready2 = 1, pair_count unchanged.
REQ-036 Counter wrap and reset: preload pair_count to 0xFFFFFFFF and accept one output -> pair_count = 0; then rst_n = 0 mid-stream -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/stream_combiner.sv
// Two 32-bit lanes, each buffered in its own FIFO, paired by arrival index into
// one 64-bit output register with a transfer counter and a sticky lane-skew flag.
module stream_combiner #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] data_port1,
    input  logic        valid1,
    output logic        ready1,
    input  logic [31:0] data_port2,
    input  logic        valid2,
    output logic        ready2,
    output logic [63:0] master_data,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] pair_count,
    output logic        skew_err
);

    // Handshakes on every port: a word moves on a rising edge where valid and
    // ready are both 1; the source holds its word until then, ready never looks at valid.
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL     = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [31:0]   mem1_q [FIFO_DEPTH];
    logic [31:0]   mem2_q [FIFO_DEPTH];
    logic [AW-1:0] wp1_q, wp1_d, rp1_q, rp1_d;
    logic [AW-1:0] wp2_q, wp2_d, rp2_q, rp2_d;
    logic [AW:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [63:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic [31:0]   pair_count_q, pair_count_d;
    logic          skew_q, skew_d;
    logic          push1, push2, load, xfer;

    assign ready1      = (cnt1_q < FULL);
    assign ready2      = (cnt2_q < FULL);
    assign master_data = data_q;
    assign valid_out   = valid_q;
    assign pair_count  = pair_count_q;
    assign skew_err    = skew_q;

    always_comb begin
        push1 = valid1 && ready1 && !flush;
        push2 = valid2 && ready2 && !flush;
        load  = !flush && (cnt1_q != '0) && (cnt2_q != '0) && (!valid_q || ready_out);
        xfer  = valid_q && ready_out;

        wp1_d  = wp1_q;
        rp1_d  = rp1_q;
        cnt1_d = cnt1_q;
        wp2_d  = wp2_q;
        rp2_d  = rp2_q;
        cnt2_d = cnt2_q;
        if (flush) begin
            wp1_d  = '0;
            rp1_d  = '0;
            cnt1_d = '0;
            wp2_d  = '0;
            rp2_d  = '0;
            cnt2_d = '0;
        end else begin
            if (push1) wp1_d = wp1_q + PTR_ONE;
            if (push2) wp2_d = wp2_q + PTR_ONE;
            if (load) begin
                rp1_d = rp1_q + PTR_ONE;
                rp2_d = rp2_q + PTR_ONE;
            end
            if (push1 && !load) cnt1_d = cnt1_q + CNT_ONE;
            else if (!push1 && load) cnt1_d = cnt1_q - CNT_ONE;
            if (push2 && !load) cnt2_d = cnt2_q + CNT_ONE;
            else if (!push2 && load) cnt2_d = cnt2_q - CNT_ONE;
        end

        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = {mem1_q[rp1_q], mem2_q[rp2_q]};
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        // A word taken downstream is counted even if a flush lands on the same edge.
        pair_count_d = xfer ? pair_count_q + 32'd1 : pair_count_q;
        skew_d = skew_q || ((cnt1_q == FULL) && (cnt2_q == '0))
                        || ((cnt2_q == FULL) && (cnt1_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp1_q        <= '0;
            rp1_q        <= '0;
            cnt1_q       <= '0;
            wp2_q        <= '0;
            rp2_q        <= '0;
            cnt2_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            pair_count_q <= '0;
            skew_q       <= 1'b0;
        end else begin
            wp1_q        <= wp1_d;
            rp1_q        <= rp1_d;
            cnt1_q       <= cnt1_d;
            wp2_q        <= wp2_d;
            rp2_q        <= rp2_d;
            cnt2_q       <= cnt2_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            pair_count_q <= pair_count_d;
            skew_q       <= skew_d;
        end
    end

    // Storage needs no reset: occupancy counters decide what is readable.
    always_ff @(posedge clk) begin
        if (push1) mem1_q[wp1_q] <= data_port1;
        if (push2) mem2_q[wp2_q] <= data_port2;
    end

endmodule

// File: tb/tb_stream_combiner.sv
// Bench for stream_combiner: directed scenarios plus randomized traffic checked
// against a queue-based lane/pairing model.
module tb_stream_combiner;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [31:0] data_port1, data_port2;
    logic        valid1, valid2, ready_out;
    logic        ready1, ready2, valid_out, skew_err;
    logic [63:0] master_data;
    logic [31:0] pair_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: lane contents, output register, counter, error flag.
    logic [31:0] m_q1[$];
    logic [31:0] m_q2[$];
    logic        m_vo;
    logic [63:0] m_data;
    logic [31:0] m_cnt;
    logic        m_skew;
    logic [63:0] exp_q[$];

    stream_combiner #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .data_port1(data_port1), .valid1(valid1), .ready1(ready1),
        .data_port2(data_port2), .valid2(valid2), .ready2(ready2),
        .master_data(master_data), .valid_out(valid_out), .ready_out(ready_out),
        .pair_count(pair_count), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Advance one edge, updating the model from the inputs currently driven.
    task automatic tick();
        bit acc1, acc2, ld, xf;
        if (!rst_n) begin
            m_q1.delete(); m_q2.delete();
            m_vo = 1'b0; m_data = '0; m_cnt = '0; m_skew = 1'b0;
        end else begin
            if ((m_q1.size() == D && m_q2.size() == 0) ||
                (m_q2.size() == D && m_q1.size() == 0)) m_skew = 1'b1;
            xf = m_vo && ready_out;
            if (xf) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                m_q1.delete(); m_q2.delete();
                m_vo = 1'b0;
            end else begin
                acc1 = valid1 && (m_q1.size() < D);
                acc2 = valid2 && (m_q2.size() < D);
                ld = (m_q1.size() > 0) && (m_q2.size() > 0) && (!m_vo || ready_out);
                if (ld) begin
                    m_data = {m_q1.pop_front(), m_q2.pop_front()};
                    m_vo = 1'b1;
                end else if (xf) begin
                    m_vo = 1'b0;
                end
                if (acc1) m_q1.push_back(data_port1);
                if (acc2) m_q2.push_back(data_port2);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; flush = 1'b0; valid1 = 1'b0; valid2 = 1'b0; ready_out = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b1; valid1 = 1'b1; valid2 = 1'b1; ready_out = 1'b1;
        data_port1 = $urandom; data_port2 = $urandom;
        tick(); tick();
        flush = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        n_cmp++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL reset_ready1: got %b want 1", ready1); end
        n_cmp++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL reset_ready2: got %b want 1", ready2); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (master_data !== 64'h0) begin n_err++; $display("FAIL reset_master_data: got %h want 0", master_data); end
        n_cmp++; if (pair_count !== 32'h0) begin n_err++; $display("FAIL reset_pair_count: got %0d want 0", pair_count); end
        n_cmp++; if (skew_err !== 1'b0) begin n_err++; $display("FAIL reset_skew_err: got %b want 0", skew_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_balanced();
        data_port1 = 32'h1111_1111; data_port2 = 32'h2222_2222;
        valid1 = 1'b1; valid2 = 1'b1; ready_out = 1'b1;
        tick();
        valid1 = 1'b0; valid2 = 1'b0;
        tick();
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL balanced_valid: got %b want 1", valid_out); end
        n_cmp++; if (master_data !== 64'h1111_1111_2222_2222) begin n_err++; $display("FAIL balanced_data: got %h want 1111111122222222", master_data); end
        tick();
        n_cmp++; if (pair_count !== 32'd1) begin n_err++; $display("FAIL balanced_count: got %0d want 1", pair_count); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL balanced_valid_clear: got %b want 0", valid_out); end
    endtask

    task automatic test_skewed();
        logic [31:0] a[4];
        logic [31:0] b[4];
        logic [63:0] e;
        reset_pulse();
        exp_q.delete();
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a[k] = $urandom; data_port1 = a[k]; valid1 = 1'b1;
            tick();
        end
        valid1 = 1'b0;
        n_cmp++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL skew_ready1_full: got %b want 0", ready1); end
        for (int k = 0; k < 4; k++) begin
            b[k] = $urandom;
            exp_q.push_back({a[k], b[k]});
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (c < 4) begin data_port2 = b[c]; valid2 = 1'b1; end
            else valid2 = 1'b0;
            tick();
            if (valid_out === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++; if (master_data !== e) begin n_err++; $display("FAIL skew_pair: got %h want %h", master_data, e); end
            end
        end
        valid2 = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL skew_missing: got %0d pairs left want 0", exp_q.size()); end
        n_cmp++; if (skew_err !== 1'b1) begin n_err++; $display("FAIL skew_flag: got %b want 1", skew_err); end
        n_cmp++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL skew_ready1_free: got %b want 1", ready1); end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        bit a1, a2;
        reset_pulse();
        data_port1 = $urandom; data_port2 = $urandom;
        for (int c = 0; c < 60; c++) begin
            valid1 = (c < 40); valid2 = (c < 40);
            ready_out = !(c >= 10 && c < 20);
            a1 = valid1 && (m_q1.size() < D);
            a2 = valid2 && (m_q2.size() < D);
            held = master_data;
            tick();
            if (a1) data_port1 = $urandom;
            if (a2) data_port2 = $urandom;
            n_cmp++; if (ready1 !== (m_q1.size() < D)) begin n_err++; $display("FAIL bp_ready1 c=%0d: got %b want %b", c, ready1, m_q1.size() < D); end
            n_cmp++; if (ready2 !== (m_q2.size() < D)) begin n_err++; $display("FAIL bp_ready2 c=%0d: got %b want %b", c, ready2, m_q2.size() < D); end
            n_cmp++; if (valid_out !== m_vo) begin n_err++; $display("FAIL bp_valid c=%0d: got %b want %b", c, valid_out, m_vo); end
            if (m_vo) begin
                n_cmp++; if (master_data !== m_data) begin n_err++; $display("FAIL bp_data c=%0d: got %h want %h", c, master_data, m_data); end
            end
            if (c > 10 && c < 20) begin
                n_cmp++; if (master_data !== held) begin n_err++; $display("FAIL bp_stable c=%0d: got %h want %h", c, master_data, held); end
            end
            if (c == 19) begin
                n_cmp++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b%b want 00", ready1, ready2); end
            end
        end
        n_cmp++; if (pair_count !== m_cnt) begin n_err++; $display("FAIL bp_count: got %0d want %0d", pair_count, m_cnt); end
    endtask

    task automatic test_random();
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            valid1 = ($urandom_range(0, 3) != 0);
            valid2 = ($urandom_range(0, 4) != 0);
            ready_out = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            data_port1 = $urandom; data_port2 = $urandom;
            tick();
            n_cmp++; if (ready1 !== (m_q1.size() < D)) begin n_err++; $display("FAIL rnd_ready1 c=%0d: got %b want %b", c, ready1, m_q1.size() < D); end
            n_cmp++; if (ready2 !== (m_q2.size() < D)) begin n_err++; $display("FAIL rnd_ready2 c=%0d: got %b want %b", c, ready2, m_q2.size() < D); end
            n_cmp++; if (valid_out !== m_vo) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, valid_out, m_vo); end
            if (m_vo) begin
                n_cmp++; if (master_data !== m_data) begin n_err++; $display("FAIL rnd_data c=%0d: got %h want %h", c, master_data, m_data); end
            end
            n_cmp++; if (pair_count !== m_cnt) begin n_err++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, pair_count, m_cnt); end
            n_cmp++; if (skew_err !== m_skew) begin n_err++; $display("FAIL rnd_skew c=%0d: got %b want %b", c, skew_err, m_skew); end
        end
        flush = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int outs = 0;
        int gaps = 0;
        reset_pulse();
        ready_out = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            valid1 = (sent < 1000); valid2 = (sent < 1000);
            data_port1 = $urandom; data_port2 = $urandom;
            tick();
            if (valid1) sent++;
            if (valid_out === 1'b1) begin
                outs++;
                n_cmp++; if (master_data !== m_data) begin n_err++; $display("FAIL b2b_data n=%0d: got %h want %h", outs, master_data, m_data); end
            end else if (outs > 0 && outs < 1000) begin
                gaps++;
            end
        end
        valid1 = 1'b0; valid2 = 1'b0;
        n_cmp++; if (outs != 1000) begin n_err++; $display("FAIL b2b_outputs: got %0d want 1000", outs); end
        n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
        n_cmp++; if (pair_count !== 32'd1000) begin n_err++; $display("FAIL b2b_count: got %0d want 1000", pair_count); end
    endtask

    task automatic test_flush();
        logic [31:0] x, y;
        reset_pulse();
        data_port1 = $urandom; data_port2 = $urandom;
        valid1 = 1'b1; valid2 = 1'b1;
        tick();
        valid1 = 1'b0; valid2 = 1'b0;
        tick();
        data_port1 = $urandom; data_port2 = $urandom; valid1 = 1'b1; valid2 = 1'b1;
        tick();
        data_port1 = $urandom; valid2 = 1'b0;
        tick();
        valid1 = 1'b0;
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", valid_out); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid_out); end
        n_cmp++; if (ready1 !== 1'b1 || ready2 !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b%b want 11", ready1, ready2); end
        n_cmp++; if (pair_count !== 32'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", pair_count); end
        x = $urandom; y = $urandom;
        data_port1 = x; data_port2 = y; valid1 = 1'b1; valid2 = 1'b1; ready_out = 1'b1;
        tick();
        valid1 = 1'b0; valid2 = 1'b0;
        tick();
        n_cmp++; if (valid_out !== 1'b1 || master_data !== {x, y}) begin n_err++; $display("FAIL flush_fresh: got %b/%h want 1/%h", valid_out, master_data, {x, y}); end
    endtask

    task automatic test_wrap_and_reset();
        reset_pulse();
        data_port1 = $urandom; data_port2 = $urandom;
        valid1 = 1'b1; valid2 = 1'b1;
        tick();
        valid1 = 1'b0; valid2 = 1'b0;
        tick();
        force dut.pair_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pair_count_q;
        m_cnt = 32'hFFFF_FFFF;
        ready_out = 1'b1;
        tick();
        n_cmp++; if (pair_count !== 32'd0) begin n_err++; $display("FAIL wrap_count: got %h want 0", pair_count); end
        for (int c = 0; c < 5; c++) begin
            data_port1 = $urandom; data_port2 = $urandom;
            valid1 = 1'b1; valid2 = (c != 2); ready_out = (c != 3);
            tick();
        end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
        n_cmp++; if (master_data !== 64'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", master_data); end
        n_cmp++; if (pair_count !== 32'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", pair_count); end
        n_cmp++; if (skew_err !== 1'b0) begin n_err++; $display("FAIL midrst_skew: got %b want 0", skew_err); end
        n_cmp++; if (ready1 !== 1'b1 || ready2 !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b%b want 11", ready1, ready2); end
        rst_n = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_stale c=%0d: got %b want 0", c, valid_out); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid1 = 1'b0; valid2 = 1'b0; ready_out = 1'b0;
        data_port1 = '0; data_port2 = '0;
        m_vo = 1'b0; m_data = '0; m_cnt = '0; m_skew = 1'b0;
        @(negedge clk);
        test_reset();
        test_balanced();
        test_skewed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_flush();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
